led_fader: RTL and testbench

Downstream consumer of the clock-scaler output that replaces the hard on/off LED rotation with a fading chase. Each rising edge of the slow scaler output moves the active LED's brightness one step up or down. A PWM generator turns that brightness into duty-cycled drive on D1–D5. Everything runs on the board clock; the scaler output is used only as a step strobe.

---
 rtl/led_fader.sv | 113 +++++++++++
 tb/tb_led_fader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// rtl/led_fader.sv - fading LED chase: step-driven brightness FSM feeding a shadowed PWM on D1-D5
module led_fader #(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  input  logic hold,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(FADE_STEP);

  typedef enum logic {RISE, FALL} state_t;

  state_t              state, state_nx;
  logic [PWM_BITS-1:0] bright, bright_nx;
  logic [2:0]          idx, idx_nx;
  logic                step_prev;
  logic                step_edge;
  logic                step_take;
  logic [PWM_BITS:0]   sum;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_sh;
  logic [2:0]          idx_sh;
  logic [4:0]          d_q, d_nx;

  assign step_edge = step_in & ~step_prev;
  assign step_take = step_edge & ~hold;
  // One extra bit so the add can be saturated instead of wrapping
  assign sum = {1'b0, bright} + STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RISE;
      bright    <= '0;
      idx       <= '0;
      step_prev <= 1'b1;
    end else begin
      state     <= state_nx;
      bright    <= bright_nx;
      idx       <= idx_nx;
      step_prev <= step_in;
    end
  end

  always_comb begin
    state_nx  = state;
    bright_nx = bright;
    idx_nx    = idx;
    if (step_take) begin
      case (state)
        RISE: begin
          if (sum >= {1'b0, MAX}) begin
            bright_nx = MAX;
            state_nx  = FALL;
          end else begin
            bright_nx = sum[PWM_BITS-1:0];
          end
        end
        FALL: begin
          // Underflow is decided before truncation; reaching zero hands over to the next LED
          if ({1'b0, bright} <= STEP) begin
            bright_nx = '0;
            idx_nx    = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            state_nx  = RISE;
          end else begin
            bright_nx = bright - STEP[PWM_BITS-1:0];
          end
        end
        default: state_nx = RISE;
      endcase
    end
  end

  always_comb begin
    d_nx = '0;
    for (int k = 0; k < 5; k++) begin
      d_nx[k] = (idx_sh == 3'(k)) && (pwm_cnt < duty_sh);
    end
  end

  // Shadows reload only at the period boundary so every PWM period is whole
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_sh <= '0;
      idx_sh  <= '0;
      d_q     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == MAX) begin
        duty_sh <= bright;
        idx_sh  <= idx;
      end
      d_q <= d_nx;
    end
  end

  assign D1 = d_q[0];
  assign D2 = d_q[1];
  assign D3 = d_q[2];
  assign D4 = d_q[3];
  assign D5 = d_q[4];

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - self-checking bench for led_fader against a cycle-level arithmetic model
module tb_led_fader;

  localparam int PWM_BITS  = 4;
  localparam int FADE_STEP = 5;
  localparam int MAXV      = 15;

  logic clk = 1'b0;
  logic rst, step_in, hold;
  logic D1, D2, D3, D4, D5;
  logic [4:0] dout;

  int n_chk = 0;
  int n_fail = 0;

  int m_bright, m_idx, m_cnt, m_duty, m_sel;
  bit m_up, m_prev;
  logic [4:0] m_d;

  led_fader #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) dut (
    .clk(clk), .rst(rst), .step_in(step_in), .hold(hold),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
  );

  assign dout = {D5, D4, D3, D2, D1};

  always #5 clk = ~clk;

  // Reference: brightness walks up/down in FADE_STEP units with clamping,
  // the LED being lit for the first "duty" counts of each 16-cycle period
  always @(posedge clk) begin
    if (rst) begin
      m_d = '0; m_bright = 0; m_idx = 0; m_up = 1; m_cnt = 0;
      m_duty = 0; m_sel = 0; m_prev = 1;
    end else begin
      m_d = '0;
      if (m_cnt < m_duty) m_d[m_sel] = 1'b1;
      if (m_cnt == MAXV) begin
        m_duty = m_bright;
        m_sel  = m_idx;
      end
      m_cnt = (m_cnt + 1) % (MAXV + 1);
      if (step_in && !m_prev && !hold) begin
        if (m_up) begin
          m_bright = (m_bright + FADE_STEP > MAXV) ? MAXV : m_bright + FADE_STEP;
          if (m_bright == MAXV) m_up = 0;
        end else begin
          m_bright = (m_bright < FADE_STEP) ? 0 : m_bright - FADE_STEP;
          if (m_bright == 0) begin
            m_idx = (m_idx + 1) % 5;
            m_up  = 1;
          end
        end
      end
      m_prev = step_in;
    end
  end

  task automatic run_cycles(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (dout !== m_d) bad++;
    end
  endtask

  task automatic edge_and_wait(input int gap, output int bad);
    int b1, b2;
    step_in = 1'b1;
    run_cycles(1, b1);
    step_in = 1'b0;
    run_cycles(gap, b2);
    bad = b1 + b2;
  endtask

  task automatic do_reset();
    int b;
    rst = 1'b1; step_in = 1'b0; hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(1, b);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; step_in = 1'b1; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (dout !== 5'b0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: got %b want 00000", i, dout);
      end
    end
    rst = 1'b0;
    run_cycles(40, bad);
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_hold_high: %0d cycles differ, want 0", bad); end
    n_chk++;
    if (dut.bright !== 4'd0) begin n_fail++; $display("FAIL reset_no_edge: bright %0d want 0", dut.bright); end
    step_in = 1'b0;
    run_cycles(2, bad);
    edge_and_wait(32, bad);
    n_chk++;
    if (dut.bright !== 4'd5 || bad !== 0) begin
      n_fail++; $display("FAIL reset_first_edge: bright %0d want 5, %0d bad cycles", dut.bright, bad);
    end
  endtask

  task automatic test_ramp();
    int exp_b [6] = '{5, 10, 15, 10, 5, 0};
    int bad, hi1, hi2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      edge_and_wait(32 + $urandom_range(0, 8), bad);
      n_chk++;
      if (dut.bright !== 4'(exp_b[i]) || bad !== 0) begin
        n_fail++;
        $display("FAIL ramp_step%0d: bright %0d want %0d, %0d bad cycles", i, dut.bright, exp_b[i], bad);
      end
    end
    n_chk++;
    if (dut.idx !== 3'd1) begin n_fail++; $display("FAIL ramp_idx: idx %0d want 1", dut.idx); end
    edge_and_wait(34, bad);
    hi1 = 0; hi2 = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      hi1 += int'(D1);
      hi2 += int'(D2);
    end
    n_chk++;
    if (hi2 !== 10 || hi1 !== 0 || bad !== 0) begin
      n_fail++; $display("FAIL ramp_handover: D2 highs %0d want 10, D1 highs %0d want 0, bad %0d", hi2, hi1, bad);
    end
  endtask

  task automatic test_duty();
    int bad, hi, others;
    do_reset();
    edge_and_wait(20, bad);
    edge_and_wait(40, bad);
    hi = 0; others = 0; bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      hi += int'(D1);
      if (dout[4:1] !== 4'b0) others++;
      if (dout !== m_d) bad++;
    end
    n_chk++;
    if (hi !== 40) begin n_fail++; $display("FAIL duty_d1: %0d highs want 40", hi); end
    n_chk++;
    if (others !== 0 || bad !== 0) begin
      n_fail++; $display("FAIL duty_others: %0d cycles with D2-D5 high want 0, %0d model diffs", others, bad);
    end
  endtask

  task automatic test_index_wrap();
    int order[$];
    int bad, gap, lit;
    do_reset();
    bad = 0;
    for (int e = 0; e < 30; e++) begin
      gap = $urandom_range(20, 40);
      for (int c = 0; c <= gap; c++) begin
        step_in = (c == 0);
        @(posedge clk);
        @(negedge clk);
        if (dout !== m_d) bad++;
        if (dout != 5'b0) begin
          lit = $clog2(int'(dout));
          if (order.size() == 0 || order[$] != lit) order.push_back(lit);
        end
      end
    end
    step_in = 1'b0;
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL wrap_model: %0d cycles differ want 0", bad); end
    n_chk++;
    if (order.size() !== 5) begin
      n_fail++; $display("FAIL wrap_order_len: %0d LEDs visited want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (order[i] !== i) begin n_fail++; $display("FAIL wrap_order%0d: D%0d want D%0d", i, order[i] + 1, i + 1); end
      end
    end
    n_chk++;
    if (dut.idx !== 3'd0 || dut.bright !== 4'd0) begin
      n_fail++; $display("FAIL wrap_end: idx %0d bright %0d want 0 0", dut.idx, dut.bright);
    end
    edge_and_wait(20, bad);
    n_chk++;
    if (dut.bright !== 4'd5) begin n_fail++; $display("FAIL wrap_rise: bright %0d want 5", dut.bright); end
  endtask

  task automatic test_hold_coincidence();
    int bad, tot, guard, hi_old, hi_new;
    do_reset();
    edge_and_wait(20, bad);
    hold = 1'b1;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      edge_and_wait($urandom_range(1, 10), bad);
      tot += bad;
    end
    hold = 1'b0;
    run_cycles(3, bad);
    tot += bad;
    n_chk++;
    if (dut.bright !== 4'd5 || tot !== 0) begin
      n_fail++; $display("FAIL hold_drop: bright %0d want 5, %0d bad cycles", dut.bright, tot);
    end
    guard = 0;
    while (m_cnt != MAXV && guard < 20) begin
      run_cycles(1, bad);
      guard++;
    end
    n_chk++;
    if (guard >= 20) begin n_fail++; $display("FAIL coinc_align: no wrap within %0d cycles want <20", guard); end
    step_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_in = 1'b0;
    n_chk++;
    if (dut.bright !== 4'd10) begin n_fail++; $display("FAIL coinc_bright: %0d want 10", dut.bright); end
    hi_old = 0; hi_new = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 16) hi_old += int'(D1); else hi_new += int'(D1);
    end
    n_chk++;
    if (hi_old !== 5 || hi_new !== 10) begin
      n_fail++; $display("FAIL coinc_duty: periods gave %0d,%0d highs want 5,10", hi_old, hi_new);
    end
  endtask

  task automatic test_mid_reset();
    int bad, tot, hi;
    do_reset();
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      edge_and_wait(20, bad);
      tot += bad;
    end
    n_chk++;
    if (dut.bright !== 4'd10 || dut.idx !== 3'd2 || tot !== 0) begin
      n_fail++; $display("FAIL midrst_setup: bright %0d idx %0d want 10 2, %0d bad", dut.bright, dut.idx, tot);
    end
    rst = 1'b1;
    step_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step_in = 1'b0;
    n_chk++;
    if (dout !== 5'b0 || dut.bright !== 4'd0 || dut.idx !== 3'd0 || dut.pwm_cnt !== 4'd0 ||
        dut.duty_sh !== 4'd0 || dut.idx_sh !== 3'd0 || dut.step_prev !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_values: D %b bright %0d idx %0d cnt %0d duty %0d sel %0d prev %b want all 0 and prev 1",
               dout, dut.bright, dut.idx, dut.pwm_cnt, dut.duty_sh, dut.idx_sh, dut.step_prev);
    end
    run_cycles(1, bad);
    edge_and_wait(40, bad);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dout[0]) hi++;
      if (dout[4:1] !== 4'b0) hi += 100;
    end
    n_chk++;
    if (dut.bright !== 4'd5 || hi !== 10 || bad !== 0) begin
      n_fail++; $display("FAIL midrst_restart: bright %0d want 5, D1 score %0d want 10, bad %0d", dut.bright, hi, bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; step_in = 1'b0; hold = 1'b0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_duty();
    test_index_wrap();
    test_hold_coincidence();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
